// File: rtl/mem_stage_unit.sv
// mem_stage_unit: MEM stage of the multicycle MIPS pipeline.
// Drives a request/ready data-memory port for loads and stores. Holds the
// upstream stages with a combinational freeze while an access is outstanding,
// and registers the MEM/WB pipeline outputs for write-back.
// Optional feature macro: MEM_TIMEOUT_EN. When defined, an access that sees
// no mem_ready for TIMEOUT BUSY cycles is aborted and mem_err is set (sticky).
module mem_stage_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  // EXE/MEM register outputs
  input  logic        wb_en_in,
  input  logic        mem_r_en_in,
  input  logic        mem_w_en_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] st_val_in,
  input  logic [4:0]  dest_in,
  // data-memory port
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  // pipeline control
  output logic        freeze,
  // MEM/WB register outputs
  output logic        wb_en,
  output logic        mem_r_en,
  output logic [31:0] alu_result,
  output logic [31:0] mem_read_value,
  output logic [4:0]  dest,
  output logic [31:0] pc,
  output logic        mem_err
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // One MEM/WB pipeline entry; an all-zero value is a bubble.
  typedef struct packed {
    logic        wb_en;
    logic        mem_r_en;
    logic [31:0] alu_result;
    logic [31:0] read_value;
    logic [4:0]  dest;
    logic [31:0] pc;
  } mem_wb_t;

  state_t      state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  mem_wb_t     wb_q, wb_d;

  logic access_present;
  logic eff_load;
  logic abort_hit;
  logic release_busy;

  // A store wins when both request flags are set, so the load flag is masked.
  assign access_present = mem_r_en_in | mem_w_en_in;
  assign eff_load       = mem_r_en_in & ~mem_w_en_in;

  // A timeout below 2 would leave no cycle for the memory to answer.
  if (TIMEOUT < 2) begin : g_timeout_too_small
  end

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mem_err_q, mem_err_d;

  // Abort only when the memory has still not answered in the last allowed cycle.
  assign abort_hit = (state_q == BUSY) & ~mem_ready
                     & (cnt_q == CNT_W'(TIMEOUT - 1));

  // Counter is zero on entry to BUSY and counts BUSY cycles; error is sticky.
  always_comb begin
    cnt_d     = '0;
    mem_err_d = mem_err_q | abort_hit;
    if (state_q == BUSY) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Timeout counter and sticky error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      mem_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      mem_err_q <= mem_err_d;
    end
  end

  assign mem_err = mem_err_q;
`else
  assign abort_hit = 1'b0;
  assign mem_err   = 1'b0;
`endif

  // BUSY ends on completion or abort; freeze drops in that same cycle.
  assign release_busy = mem_ready | abort_hit;

  // Stall upstream while an access is pending; never depends on mem_rdata.
  always_comb begin
    freeze = 1'b0;
    if (!rst) begin
      if (state_q == IDLE) begin
        freeze = access_present;
      end else begin
        freeze = ~release_busy;
      end
    end
  end

  // Next-state, memory-port and MEM/WB selection for the two-state access FSM.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    wb_d        = '0;
    case (state_q)
      IDLE: begin
        if (access_present) begin
          // Launch the access; MEM/WB takes a bubble meanwhile.
          state_d     = BUSY;
          mem_req_d   = 1'b1;
          mem_we_d    = mem_w_en_in;
          mem_addr_d  = {alu_result_in[31:2], 2'b00};
          mem_wdata_d = st_val_in;
        end else begin
          // Plain ALU instruction passes straight through.
          wb_d.wb_en      = wb_en_in;
          wb_d.mem_r_en   = eff_load;
          wb_d.alu_result = alu_result_in;
          wb_d.read_value = '0;
          wb_d.dest       = dest_in;
          wb_d.pc         = pc_in;
        end
      end
      BUSY: begin
        if (mem_ready) begin
          // Completion: retire the held instruction with its load data.
          state_d         = IDLE;
          mem_req_d       = 1'b0;
          wb_d.wb_en      = wb_en_in;
          wb_d.mem_r_en   = eff_load;
          wb_d.alu_result = alu_result_in;
          wb_d.read_value = eff_load ? mem_rdata : 32'h0;
          wb_d.dest       = dest_in;
          wb_d.pc         = pc_in;
        end else if (abort_hit) begin
          // Abort: retire the instruction but suppress its register write.
          state_d         = IDLE;
          mem_req_d       = 1'b0;
          wb_d.wb_en      = 1'b0;
          wb_d.mem_r_en   = eff_load;
          wb_d.alu_result = alu_result_in;
          wb_d.read_value = '0;
          wb_d.dest       = dest_in;
          wb_d.pc         = pc_in;
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // FSM state, memory port and MEM/WB register; reset abandons any access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      wb_q        <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      wb_q        <= wb_d;
    end
  end

  assign mem_req        = mem_req_q;
  assign mem_we         = mem_we_q;
  assign mem_addr       = mem_addr_q;
  assign mem_wdata      = mem_wdata_q;
  assign wb_en          = wb_q.wb_en;
  assign mem_r_en       = wb_q.mem_r_en;
  assign alu_result     = wb_q.alu_result;
  assign mem_read_value = wb_q.read_value;
  assign dest           = wb_q.dest;
  assign pc             = wb_q.pc;

endmodule

// File: tb/tb_mem_stage_unit.sv
// Directed testbench for mem_stage_unit; covers the timeout path when
// MEM_TIMEOUT_EN is defined.
module tb_mem_stage_unit;

  logic        clk;
  logic        rst;
  logic        wb_en_in, mem_r_en_in, mem_w_en_in;
  logic [31:0] pc_in, alu_result_in, st_val_in;
  logic [4:0]  dest_in;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ready;
  logic        freeze;
  logic        wb_en, mem_r_en;
  logic [31:0] alu_result, mem_read_value, pc;
  logic [4:0]  dest;
  logic        mem_err;

  int total;
  int bad;

  mem_stage_unit #(.TIMEOUT(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .wb_en_in       (wb_en_in),
    .mem_r_en_in    (mem_r_en_in),
    .mem_w_en_in    (mem_w_en_in),
    .pc_in          (pc_in),
    .alu_result_in  (alu_result_in),
    .st_val_in      (st_val_in),
    .dest_in        (dest_in),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .mem_ready      (mem_ready),
    .freeze         (freeze),
    .wb_en          (wb_en),
    .mem_r_en       (mem_r_en),
    .alu_result     (alu_result),
    .mem_read_value (mem_read_value),
    .dest           (dest),
    .pc             (pc),
    .mem_err        (mem_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wb, input logic rd, input logic wr,
                       input logic [31:0] addr, input logic [31:0] st,
                       input logic [4:0] dst, input logic [31:0] p);
    wb_en_in      = wb;
    mem_r_en_in   = rd;
    mem_w_en_in   = wr;
    alu_result_in = addr;
    st_val_in     = st;
    dest_in       = dst;
    pc_in         = p;
  endtask

  task automatic idle_inputs();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 32'h0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst       = 1'b1;
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    idle_inputs();

    // Reset state, before any clock edge
    #2;
    check("rst_mem_req", mem_req, 0);
    check("rst_freeze", freeze, 0);
    check("rst_wb_en", wb_en, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_err", mem_err, 0);
    step();
    step();
    rst = 1'b0;
    #1;

    // ALU op passes through in one edge, no stall
    drive(1'b1, 1'b0, 1'b0, 32'h0000_0042, 32'h0, 5'd5, 32'h0000_0100);
    #1;
    check("alu_freeze", freeze, 0);
    step();
    check("alu_wb_en", wb_en, 1);
    check("alu_result", alu_result, 32'h42);
    check("alu_dest", dest, 5);
    check("alu_pc", pc, 32'h100);
    check("alu_mem_r_en", mem_r_en, 0);
    check("alu_mem_req", mem_req, 0);
    check("alu_freeze_after", freeze, 0);

    // Load at 0x404, ready 3 cycles after mem_req rises: freeze high 4 cycles
    drive(1'b1, 1'b1, 1'b0, 32'h0000_0404, 32'h0, 5'd7, 32'h0000_0104);
    #1;
    check("ld_freeze_idle", freeze, 1);
    step();
    check("ld_mem_req", mem_req, 1);
    check("ld_mem_we", mem_we, 0);
    check("ld_mem_addr", mem_addr, 32'h404);
    check("ld_wb_en_b1", wb_en, 0);
    check("ld_freeze_b1", freeze, 1);
    step();
    check("ld_wb_en_b2", wb_en, 0);
    check("ld_freeze_b2", freeze, 1);
    check("ld_req_stable", mem_req, 1);
    step();
    check("ld_wb_en_b3", wb_en, 0);
    check("ld_freeze_b3", freeze, 1);
    check("ld_addr_stable", mem_addr, 32'h404);
    step();
    check("ld_wb_en_b4", wb_en, 0);
    mem_ready = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    #1;
    check("ld_freeze_done", freeze, 0);
    step();
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    idle_inputs();
    check("ld_wb_en", wb_en, 1);
    check("ld_mem_r_en", mem_r_en, 1);
    check("ld_value", mem_read_value, 32'hDEAD_BEEF);
    check("ld_dest", dest, 7);
    check("ld_pc", pc, 32'h104);
    check("ld_req_drop", mem_req, 0);

    // Store at 0x407, ready in the first BUSY cycle
    drive(1'b0, 1'b0, 1'b1, 32'h0000_0407, 32'h1234_5678, 5'd0, 32'h0000_0108);
    #1;
    check("st_freeze_idle", freeze, 1);
    step();
    check("st_mem_req", mem_req, 1);
    check("st_mem_we", mem_we, 1);
    check("st_mem_addr", mem_addr, 32'h404);
    check("st_mem_wdata", mem_wdata, 32'h1234_5678);
    mem_ready = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    #1;
    check("st_freeze_done", freeze, 0);
    step();
    mem_ready = 1'b0;
    idle_inputs();
    check("st_req_drop", mem_req, 0);
    check("st_value", mem_read_value, 0);
    check("st_mem_r_en", mem_r_en, 0);
    check("st_alu_result", alu_result, 32'h407);
    check("st_pc", pc, 32'h108);

    // Both request flags set: treated as a store
    drive(1'b1, 1'b1, 1'b1, 32'h0000_0020, 32'hA5A5_A5A5, 5'd3, 32'h0000_010C);
    step();
    check("both_mem_we", mem_we, 1);
    check("both_wdata", mem_wdata, 32'hA5A5_A5A5);
    mem_ready = 1'b1;
    mem_rdata = 32'h0000_0055;
    step();
    mem_ready = 1'b0;
    idle_inputs();
    check("both_mem_r_en", mem_r_en, 0);
    check("both_value", mem_read_value, 0);
    check("both_wb_en", wb_en, 1);
    check("both_dest", dest, 3);

    // Back-to-back loads with mem_ready held high: 2 edges each
    mem_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 1'b1, 1'b0, 32'h10 + 32'(i * 4), 32'h0, 5'(i), 32'h200 + 32'(i * 4));
      mem_rdata = 32'h1111_1111 * i;
      #1;
      check("b2b_freeze_idle", freeze, 1);
      step();
      check("b2b_bubble", wb_en, 0);
      check("b2b_req", mem_req, 1);
      check("b2b_freeze_busy", freeze, 0);
      step();
      check("b2b_wb_en", wb_en, 1);
      check("b2b_dest", dest, i);
      check("b2b_value", mem_read_value, 32'h1111_1111 * i);
      check("b2b_pc", pc, 32'h200 + 32'(i * 4));
    end
    mem_ready = 1'b0;
    idle_inputs();
    step();
    check("b2b_no_dup", wb_en, 0);

    // Reset pulsed mid-BUSY: outputs clear without a clock edge
    drive(1'b1, 1'b1, 1'b0, 32'h0000_0808, 32'h0, 5'd9, 32'h0000_0300);
    step();
    step();
    check("mid_req_before", mem_req, 1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_req", mem_req, 0);
    check("mid_rst_freeze", freeze, 0);
    check("mid_rst_addr", mem_addr, 0);
    check("mid_rst_wb_en", wb_en, 0);
    check("mid_rst_dest", dest, 0);
    idle_inputs();
    #1;
    rst = 1'b0;
    step();
    drive(1'b1, 1'b0, 1'b0, 32'h0000_0077, 32'h0, 5'd4, 32'h0000_0310);
    #1;
    check("post_rst_freeze", freeze, 0);
    step();
    check("post_rst_alu", alu_result, 32'h77);
    check("post_rst_wb_en", wb_en, 1);
    idle_inputs();

`ifdef MEM_TIMEOUT_EN
    // No mem_ready: abort after 16 BUSY cycles, sticky error
    drive(1'b1, 1'b1, 1'b0, 32'h0000_0900, 32'h0, 5'd6, 32'h0000_0400);
    step();
    check("to_req", mem_req, 1);
    for (int k = 1; k <= 15; k++) begin
      check("to_freeze_busy", freeze, 1);
      check("to_req_held", mem_req, 1);
      step();
    end
    check("to_freeze_abort", freeze, 0);
    check("to_req_last", mem_req, 1);
    check("to_err_before", mem_err, 0);
    step();
    idle_inputs();
    check("to_req_drop", mem_req, 0);
    check("to_err", mem_err, 1);
    check("to_wb_en", wb_en, 0);
    check("to_value", mem_read_value, 0);
    check("to_dest", dest, 6);
    drive(1'b1, 1'b1, 1'b0, 32'h0000_0904, 32'h0, 5'd8, 32'h0000_0404);
    step();
    mem_ready = 1'b1;
    mem_rdata = 32'hCAFE_0001;
    step();
    mem_ready = 1'b0;
    idle_inputs();
    check("to_next_value", mem_read_value, 32'hCAFE_0001);
    check("to_err_sticky", mem_err, 1);
    rst = 1'b1;
    #1;
    check("to_err_cleared", mem_err, 0);
    rst = 1'b0;
`else
    check("no_timeout_err", mem_err, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_stage_unit.md
# mem_stage_unit

Memory stage of the multicycle MIPS pipeline. It consumes the EXE/MEM pipeline register outputs and drives a handshaked data-memory port for loads and stores. It stalls upstream stages while an access is outstanding and produces the registered MEM/WB pipeline outputs for the write-back stage.

## Interface

Parameters:
- `TIMEOUT`, 16, cycles allowed in BUSY before an access is aborted (used only with `MEM_TIMEOUT_EN`); minimum 2.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `wb_en_in`  in  1  write-back enable from the EXE/MEM register.
- `mem_r_en_in`  in  1  load request from the EXE/MEM register.
- `mem_w_en_in`  in  1  store request from the EXE/MEM register.
- `pc_in`  in  32  PC of the instruction in MEM.
- `alu_result_in`  in  32  ALU result; byte address for loads and stores.
- `st_val_in`  in  32  store data.
- `dest_in`  in  5  destination register number.
- `mem_req`  out  1  memory request, registered.
- `mem_we`  out  1  1 = write, 0 = read; valid while `mem_req` is high.
- `mem_addr`  out  32  word-aligned address, `{alu_result_in[31:2],2'b00}`, registered.
- `mem_wdata`  out  32  store data, registered.
- `mem_rdata`  in  32  read data; valid when `mem_ready` is high.
- `mem_ready`  in  1  one-cycle completion strobe from memory.
- `freeze`  out  1  combinational stall to the IF, ID and EXE registers.
- `wb_en`  out  1  MEM/WB write-back enable.
- `mem_r_en`  out  1  MEM/WB load flag (selects `mem_read_value` in WB).
- `alu_result`  out  32  MEM/WB ALU result.
- `mem_read_value`  out  32  MEM/WB load data.
- `dest`  out  5  MEM/WB destination register.
- `pc`  out  32  MEM/WB PC.
- `mem_err`  out  1  sticky access-timeout flag.

## Operation

- FSM states: IDLE and BUSY. Reset state is IDLE.
- An access is *present* when `mem_r_en_in | mem_w_en_in`. If both are set, the access is a store: `mem_we=1`, and `mem_r_en` is cleared on output.
- IDLE, no access present:
  - MEM/WB loads the input fields every cycle.
  - `mem_read_value` loads 0.
  - `freeze=0`.
- IDLE, access present:
  - `freeze=1`.
  - MEM/WB loads a bubble (all fields 0).
  - On the next edge: go to BUSY, set `mem_req=1`, and latch `mem_we`, `mem_addr` and `mem_wdata`.
- BUSY:
  - `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` stay stable until completion.
  - `freeze = ~mem_ready`.
  - Each cycle without `mem_ready`, MEM/WB loads a bubble.
- BUSY with `mem_ready=1`, completion edge:
  - MEM/WB loads the instruction fields.
  - `mem_read_value <= mem_rdata` for a load, 0 for a store.
  - `mem_req <= 0`; return to IDLE.
- `freeze` is low during the completion cycle, so upstream advances on the same edge. The next instruction is then evaluated in IDLE.
- `mem_ready` in IDLE is ignored.
- Reset of every output and all state is 0, and the FSM returns to IDLE.
- Reset mid-access: `mem_req` drops immediately (asynchronously) and the access is abandoned. Memory must tolerate a dropped request.

## Timing

- Non-memory instruction: MEM/WB outputs valid 1 cycle after the inputs are presented; no stall.
- Memory instruction: the MEM/WB result appears `N+2` edges after the inputs are first presented, where `N` is the number of BUSY cycles before `mem_ready`.
  - Minimum is 2 edges (`mem_ready` in the first BUSY cycle).
  - `freeze` is high for `N+1` cycles.
- `mem_req` rises 1 edge after the access is first presented.
- `freeze` must never depend on `mem_rdata`.

## Configuration

- `MEM_TIMEOUT_EN` defined:
  - A counter clears on entry to BUSY and increments each BUSY cycle.
  - If the counter reaches `TIMEOUT-1` without `mem_ready`, the access is aborted on the next edge:
    - `mem_req <= 0`, return to IDLE.
    - `mem_err <= 1`, sticky until `rst`.
    - MEM/WB loads the instruction with `wb_en=0` and `mem_read_value=0`.
  - `freeze` is low in the abort cycle.
- `MEM_TIMEOUT_EN` undefined: BUSY waits indefinitely; `mem_err` is constant 0; no counter logic is present.

## Test plan

- ALU op, `wb_en_in=1`, `alu_result_in=0x0000_0042`, `dest_in=5` -> next edge `wb_en=1`, `alu_result=0x42`, `dest=5`, `freeze` never high.
- Load at `0x0000_0404`; `mem_ready` with `mem_rdata=0xDEAD_BEEF` 3 cycles after `mem_req` rises -> `mem_addr=0x404`, `mem_we=0`, `freeze` high 4 cycles, then `mem_r_en=1`, `mem_read_value=0xDEADBEEF`; `wb_en=0` on every frozen cycle.
- Store of `0x1234_5678` at `0x0000_0407`, `mem_ready` in the first BUSY cycle -> `mem_addr=0x404`, `mem_we=1`, `mem_wdata=0x12345678`, 2-cycle latency, `mem_read_value=0`.
- Back-to-back loads with `mem_ready` held high -> each load takes exactly 2 edges; there is no lost or duplicated MEM/WB write.
- `rst` pulsed mid-BUSY -> `mem_req`, `freeze` and all MEM/WB outputs go to 0 without a clock edge; the FSM restarts in IDLE.
- `MEM_TIMEOUT_EN`, `TIMEOUT=16`, `mem_ready` never asserted -> `mem_req` falls after 16 BUSY cycles, `mem_err=1` and `wb_en=0` for that instruction, and `mem_err` stays 1 through later accesses until `rst`.
